seq_window_ctrl: RTL and testbench

SEQ_WINDOW_CTRL -- requirements
Module: seq_window_ctrl

---
 rtl/seq_ctrl_pkg.sv | 25 ++
 rtl/seq_det_mealy.sv | 55 +++++
 rtl/seq_window_ctrl.sv | 109 ++++++++++
 tb/tb_seq_window_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types for the serial window controller: FSM states, detector
// history states and the 2-bit match codes passed from detector to counters.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Detector history: the longest useful suffix of the bits seen so far.
    typedef enum logic [1:0] {
        H_NONE = 2'd0,
        H_1    = 2'd1,
        H_10   = 2'd2,
        H_11   = 2'd3
    } hist_e;

    typedef logic [1:0] match_t;

    localparam match_t MATCH_NONE = 2'b00;
    localparam match_t MATCH_101  = 2'b01;
    localparam match_t MATCH_110  = 2'b10;

endpackage

// File: rtl/seq_det_mealy.sv
// Overlapping "101" / "110" Mealy detector. The match output is
// combinational on the current bit plus history and only fires on a valid
// bit; clr_i wipes the history so nothing carries into a new window.
module seq_det_mealy
    import seq_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   clr_i,
    input  logic   bit_i,
    input  logic   bit_vld_i,
    output match_t match_o
);

    hist_e hist_q, hist_d;

    // History register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hist_q <= H_NONE;
        else          hist_q <= hist_d;
    end

    // Mealy transition and match decode; after "101" the tail "1" is kept,
    // after "110" the tail "10" is kept, so overlapping matches are counted
    always_comb begin
        hist_d  = hist_q;
        match_o = MATCH_NONE;
        if (clr_i) begin
            hist_d = H_NONE;
        end else if (bit_vld_i) begin
            unique case (hist_q)
                H_NONE: hist_d = bit_i ? H_1 : H_NONE;
                H_1:    hist_d = bit_i ? H_11 : H_10;
                H_10: begin
                    if (bit_i) begin
                        match_o = MATCH_101;
                        hist_d  = H_1;
                    end else begin
                        hist_d  = H_NONE;
                    end
                end
                H_11: begin
                    if (bit_i) begin
                        hist_d  = H_11;
                    end else begin
                        match_o = MATCH_110;
                        hist_d  = H_10;
                    end
                end
                default: hist_d = H_NONE;
            endcase
        end
    end

endmodule

// File: rtl/seq_window_ctrl.sv
// Windowed pattern counter: opens a window of i_len valid bits, counts
// overlapping "101" and "110" matches, then holds the result until accepted.
// Define SEQ_WINDOW_CTRL_SATURATE_EN to make the counters stick at all-ones
// instead of wrapping.
module seq_window_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_bit,
    input  logic             i_bit_valid,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_cnt_101,
    output logic [CNT_W-1:0] o_cnt_110,
    output logic             o_done_valid,
    input  logic             i_done_ready
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef SEQ_WINDOW_CTRL_SATURATE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`endif

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, bcnt_q;
    logic [CNT_W-1:0] c101_q, c110_q, c101_d, c110_d;
    logic             start_acc, consume, last_bit;
    match_t           match;

    assign start_acc = (state_q == ST_IDLE) && i_start;
    assign consume   = (state_q == ST_RUN) && i_bit_valid;
    // bcnt_q counts bits already consumed, so it never needs to reach len_q
    // and cannot overflow even for an all-ones length
    assign last_bit  = consume && (bcnt_q == len_q - LEN_ONE);

    seq_det_mealy u_det (
        .clk       (i_clk),
        .reset_n   (i_reset_n),
        .clr_i     (start_acc),
        .bit_i     (i_bit),
        .bit_vld_i (consume),
        .match_o   (match)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // FSM next state; a zero-length window reports immediately
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (i_start) state_d = (i_len == '0) ? ST_REPORT : ST_RUN;
            ST_RUN:    if (last_bit) state_d = ST_REPORT;
            ST_REPORT: if (i_done_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy       = (state_q != ST_IDLE);
        o_done_valid = (state_q == ST_REPORT);
    end

    // Counter increment on the match reported for the bit being consumed
    always_comb begin
        c101_d = c101_q;
        c110_d = c110_q;
`ifdef SEQ_WINDOW_CTRL_SATURATE_EN
        if (match == MATCH_101 && c101_q != CNT_MAX) c101_d = c101_q + CNT_ONE;
        if (match == MATCH_110 && c110_q != CNT_MAX) c110_d = c110_q + CNT_ONE;
`else
        if (match == MATCH_101) c101_d = c101_q + CNT_ONE;
        if (match == MATCH_110) c110_d = c110_q + CNT_ONE;
`endif
    end

    // Window datapath: latch length and clear on accept, advance on each bit
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len_q  <= '0;
            bcnt_q <= '0;
            c101_q <= '0;
            c110_q <= '0;
        end else if (start_acc) begin
            len_q  <= i_len;
            bcnt_q <= '0;
            c101_q <= '0;
            c110_q <= '0;
        end else if (consume) begin
            bcnt_q <= bcnt_q + LEN_ONE;
            c101_q <= c101_d;
            c110_q <= c110_d;
        end
    end

    assign o_cnt_101 = c101_q;
    assign o_cnt_110 = c110_q;

endmodule

// File: tb/tb_seq_window_ctrl.sv
// Directed bench for seq_window_ctrl, built with CNT_W=2 so counter wrap and
// saturation are reachable with short windows. Honours
// SEQ_WINDOW_CTRL_SATURATE_EN for the expected wrap/saturate values.
module tb_seq_window_ctrl;

    localparam int LEN_W = 8;
    localparam int CNT_W = 2;
`ifdef SEQ_WINDOW_CTRL_SATURATE_EN
    localparam int EXP_W17 = 3;
`else
    localparam int EXP_W17 = 0;
`endif

    logic             i_clk = 1'b0;
    logic             i_reset_n = 1'b1;
    logic             i_start = 1'b0;
    logic [LEN_W-1:0] i_len = '0;
    logic             i_bit = 1'b0;
    logic             i_bit_valid = 1'b0;
    logic             i_done_ready = 1'b0;
    logic             o_busy, o_done_valid;
    logic [CNT_W-1:0] o_cnt_101, o_cnt_110;

    int n_chk  = 0;
    int n_pass = 0;

    seq_window_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_bit        (i_bit),
        .i_bit_valid  (i_bit_valid),
        .o_busy       (o_busy),
        .o_cnt_101    (o_cnt_101),
        .o_cnt_110    (o_cnt_110),
        .o_done_valid (o_done_valid),
        .i_done_ready (i_done_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic start_win(input int len);
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    // Sends n bits of pat, leftmost first; gap inserts an idle cycle after each
    task automatic send_seq(input logic [31:0] pat, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            i_bit_valid = 1'b1;
            i_bit       = pat[n-1-i];
            @(posedge i_clk); #1;
            i_bit_valid = 1'b0;
            if (gap) begin @(posedge i_clk); #1; end
        end
    endtask

    // Sends n bits of 1,0,1,0,...
    task automatic send_alt(input int n);
        for (int i = 0; i < n; i++) begin
            i_bit_valid = 1'b1;
            i_bit       = (i % 2 == 0);
            @(posedge i_clk); #1;
        end
        i_bit_valid = 1'b0;
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) begin
            i_bit_valid = 1'b1;
            i_bit       = 1'b1;
            @(posedge i_clk); #1;
        end
        i_bit_valid = 1'b0;
    endtask

    task automatic ack(input string tag);
        i_done_ready = 1'b1;
        @(posedge i_clk); #1;
        i_done_ready = 1'b0;
        @(negedge i_clk);
        chk({tag, "_idle_busy"}, o_busy, 0);
        chk({tag, "_idle_done"}, o_done_valid, 0);
    endtask

    task automatic chk_report(input string tag, input int e101, input int e110);
        @(negedge i_clk);
        chk({tag, "_done"}, o_done_valid, 1);
        chk({tag, "_c101"}, o_cnt_101, e101);
        chk({tag, "_c110"}, o_cnt_110, e110);
    endtask

    initial begin
        #2 i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done_valid, 0);
        chk("rst_c101", o_cnt_101, 0);
        chk("rst_c110", o_cnt_110, 0);
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;

        // 1,0,1,1,0 -> one of each; start taken on first edge after release
        start_win(5);
        send_seq(32'b1011, 4, 1'b0);
        @(negedge i_clk);
        chk("w5_pre_done", o_done_valid, 0);
        chk("w5_pre_busy", o_busy, 1);
        send_seq(32'b0, 1, 1'b0);
        chk_report("w5", 1, 1);
        @(posedge i_clk); #1;
        chk_report("w5_hold", 1, 1);
        ack("w5");

        // 1,0,1,0,1,0 with gaps and a stray start mid-run -> 2 / 0
        start_win(6);
        send_seq(32'b101, 3, 1'b1);
        i_start = 1'b1; i_len = 8'd1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        send_seq(32'b010, 3, 1'b1);
        chk_report("w6gap", 2, 0);
        ack("w6gap");

        // zero length reports immediately; starts in REPORT are dropped
        start_win(0);
        chk_report("w0", 0, 0);
        i_start = 1'b1; i_len = 8'd3;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("w0_start_ign", o_done_valid, 1);
        i_done_ready = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_done_ready = 1'b0; i_start = 1'b0;
        @(negedge i_clk);
        chk("w0_hs_busy", o_busy, 0);
        @(negedge i_clk);
        chk("w0_hs_nostart", o_busy, 0);

        // window A=1,0 then B=1,1: history must not leak into B
        start_win(2);
        send_seq(32'b10, 2, 1'b0);
        chk_report("wA", 0, 0);
        ack("wA");
        start_win(2);
        send_seq(32'b11, 2, 1'b0);
        chk_report("wB", 0, 0);
        ack("wB");

        // 2-bit counters: 7, 7 and 8 matches of "101"
        start_win(15);
        send_alt(15);
        chk_report("w15", 3, 0);
        ack("w15");
        start_win(16);
        send_alt(16);
        chk_report("w16", 3, 0);
        ack("w16");
        start_win(17);
        send_alt(17);
        chk_report("w17", EXP_W17, 0);
        ack("w17");

        // full-scale length runs all 255 bits
        start_win(255);
        send_ones(254);
        @(negedge i_clk);
        chk("w255_pre_done", o_done_valid, 0);
        chk("w255_pre_busy", o_busy, 1);
        send_ones(1);
        chk_report("w255", 0, 0);
        ack("w255");

        // reset after 3 of 8 bits discards the window
        start_win(8);
        send_seq(32'b101, 3, 1'b0);
        i_reset_n = 1'b0;
        #1;
        chk("mrst_busy", o_busy, 0);
        chk("mrst_done", o_done_valid, 0);
        chk("mrst_c101", o_cnt_101, 0);
        chk("mrst_c110", o_cnt_110, 0);
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        start_win(3);
        send_seq(32'b110, 3, 1'b0);
        chk_report("post_rst", 0, 1);
        ack("post_rst");
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("end_done", o_done_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
